// File: rtl/hw_pkg.sv
// Shared widths and types for the round-robin popcount scheduler.
package hw_pkg;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 6;
  localparam int ID_W    = 2;
  localparam int TOT_W   = 16;
  localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [ID_W-1:0]  id;
  } resp_t;
endpackage

// File: rtl/hw_rr_sched_if.sv
// Requester and response handshake bundle; the scheduler is the slave side.
interface hw_rr_sched_if;
  import hw_pkg::*;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           resp_valid;
  logic                           resp_ready;
  logic [CNT_W-1:0]               resp_count;
  logic [ID_W-1:0]                resp_id;

  modport master (output req_valid, req_data, resp_ready,
                  input  req_ready, resp_valid, resp_count, resp_id);
  modport slave  (input  req_valid, req_data, resp_ready,
                  output req_ready, resp_valid, resp_count, resp_id);
endinterface

// File: rtl/hw_popcount.sv
// Combinational Hamming weight of one DATA_W word.
module hw_popcount import hw_pkg::*; (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_W; i++) count = count + CNT_W'(data[i]);
  end
endmodule

// File: rtl/hw_rr_sched.sv
// Round-robin arbiter sharing one popcount unit, with a single-entry result
// register and a saturating running total of counted ones.
module hw_rr_sched import hw_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  hw_rr_sched_if.slave     bus,
  input  logic             clear_total,
  output logic [TOT_W-1:0] total_ones
);
  logic [ID_W-1:0]  rr_ptr, gnt_id, hi_id, lo_id, nxt_ptr;
  logic             hi_found, lo_found, gnt_found, can_accept, xfer;
  logic [CNT_W-1:0] gnt_cnt;
  logic [TOT_W:0]   tot_sum;
  resp_t            resp_q;
  logic             resp_vld;

  assign can_accept = !resp_vld || bus.resp_ready;

  // Downward scan leaves the lowest match: hi_* restricted to >= rr_ptr, lo_* wraps.
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_found = 1'b0;
    lo_id    = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (ID_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end
        lo_found = 1'b1;
        lo_id    = ID_W'(i);
      end
    end
    gnt_found = lo_found;
    gnt_id    = hi_found ? hi_id : lo_id;
  end

  // Gating with rst_n keeps a requester from seeing a handshake during reset.
  assign xfer    = gnt_found && can_accept && rst_n;
  assign nxt_ptr = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[gnt_id] = 1'b1;
  end

  hw_popcount u_pc (
    .data  (bus.req_data[gnt_id]),
    .count (gnt_cnt)
  );

  assign tot_sum = {1'b0, total_ones} + {{(TOT_W+1-CNT_W){1'b0}}, gnt_cnt};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_q     <= '0;
      resp_vld   <= 1'b0;
      rr_ptr     <= '0;
      total_ones <= '0;
    end else begin
      if (xfer) begin
        resp_q   <= '{count: gnt_cnt, id: gnt_id};
        resp_vld <= 1'b1;
        rr_ptr   <= nxt_ptr;
      end else if (bus.resp_ready) begin
        resp_vld <= 1'b0;
      end
      if (clear_total)
        total_ones <= xfer ? {{(TOT_W-CNT_W){1'b0}}, gnt_cnt} : '0;
      else if (xfer)
        total_ones <= tot_sum[TOT_W] ? TOT_MAX : tot_sum[TOT_W-1:0];
    end
  end

  assign bus.resp_valid = resp_vld;
  assign bus.resp_count = resp_q.count;
  assign bus.resp_id    = resp_q.id;
endmodule

// File: tb/tb_hw_rr_sched.sv
// Directed checks of grant order, handshake timing, back-pressure and totals.
module tb_hw_rr_sched;
  import hw_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear_total;
  logic [TOT_W-1:0] total_ones;
  int               n_run = 0;
  int               n_fail = 0;

  hw_rr_sched_if bus ();

  hw_rr_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clear_total (clear_total),
    .total_ones  (total_ones)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b1;
    clear_total    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    n_run++;
    if (bus.resp_valid !== 1'b0 || bus.resp_count !== '0 || bus.resp_id !== '0 ||
        total_ones !== '0 || bus.req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b cnt=%0d id=%0d tot=%0d rdy=%b, want 0/0/0/0/0000",
               bus.resp_valid, bus.resp_count, bus.resp_id, total_ones, bus.req_ready);
    end
    rst_n = 1'b1;
    bus.req_valid   = 4'b0001;
    bus.req_data[0] = 32'hFFFF_FFFF;
    #1;
    n_run++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    n_run++;
    if (bus.resp_valid !== 1'b1 || bus.resp_count !== 6'd32 || bus.resp_id !== 2'd0 ||
        total_ones !== 16'd32) begin
      n_fail++;
      $display("FAIL single_resp: valid=%b cnt=%0d id=%0d tot=%0d want 1/32/0/32",
               bus.resp_valid, bus.resp_count, bus.resp_id, total_ones);
    end
    step();
    n_run++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: resp_valid=%b want 0", bus.resp_valid);
    end
  endtask

  task automatic test_all_valid();
    logic [3:0] exp_rdy;
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = {32'hF, 32'h7, 32'h3, 32'h1};
    for (int i = 0; i < 8; i++) begin
      exp_rdy = 4'b0001 << (i % 4);
      #1;
      n_run++;
      if (bus.req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b want %b", i, bus.req_ready, exp_rdy);
      end
      step();
      n_run++;
      if (bus.resp_valid !== 1'b1 || bus.resp_count !== CNT_W'(i % 4 + 1) ||
          bus.resp_id !== ID_W'(i % 4)) begin
        n_fail++;
        $display("FAIL rr_resp[%0d]: valid=%b cnt=%0d id=%0d want 1/%0d/%0d",
                 i, bus.resp_valid, bus.resp_count, bus.resp_id, i % 4 + 1, i % 4);
      end
    end
    n_run++;
    if (total_ones !== 16'd20) begin
      n_fail++;
      $display("FAIL rr_total: got %0d want 20", total_ones);
    end
  endtask

  // Continues from test_all_valid: result id3/count4 held, next pointer 0.
  task automatic test_back_pressure();
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_run++;
      if (bus.req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: got %b want 0000", i, bus.req_ready);
      end
      step();
      n_run++;
      if (bus.resp_valid !== 1'b1 || bus.resp_count !== 6'd4 || bus.resp_id !== 2'd3) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b cnt=%0d id=%0d want 1/4/3",
                 i, bus.resp_valid, bus.resp_count, bus.resp_id);
      end
    end
    bus.resp_ready = 1'b1;
    #1;
    n_run++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b want 0001", bus.req_ready);
    end
    step();
    n_run++;
    if (bus.resp_valid !== 1'b1 || bus.resp_count !== 6'd1 || bus.resp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_release_resp: valid=%b cnt=%0d id=%0d want 1/1/0",
               bus.resp_valid, bus.resp_count, bus.resp_id);
    end
    idle();
    step();
  endtask

  task automatic test_pointer_skip();
    do_reset();
    bus.req_valid   = 4'b0001;
    bus.req_data[0] = 32'h1;
    step();
    bus.req_valid   = 4'b1001;
    bus.req_data[3] = 32'hF;
    #1;
    n_run++;
    if (bus.req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL skip_grant3: got %b want 1000", bus.req_ready);
    end
    step();
    n_run++;
    if (bus.resp_id !== 2'd3 || bus.resp_count !== 6'd4) begin
      n_fail++;
      $display("FAIL skip_resp3: id=%0d cnt=%0d want 3/4", bus.resp_id, bus.resp_count);
    end
    n_run++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL skip_grant0: got %b want 0001", bus.req_ready);
    end
    step();
    n_run++;
    if (bus.resp_id !== 2'd0 || bus.resp_count !== 6'd1) begin
      n_fail++;
      $display("FAIL skip_resp0: id=%0d cnt=%0d want 0/1", bus.resp_id, bus.resp_count);
    end
    idle();
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    bus.req_valid   = 4'b0001;
    bus.req_data[0] = 32'hFFFF_FFFF;
    repeat (2047) step();
    n_run++;
    if (total_ones !== 16'd65504) begin
      n_fail++;
      $display("FAIL sat_pre: got %0d want 65504", total_ones);
    end
    step();
    n_run++;
    if (total_ones !== 16'd65535) begin
      n_fail++;
      $display("FAIL sat_2048: got %0d want 65535", total_ones);
    end
    step();
    n_run++;
    if (total_ones !== 16'd65535 || bus.resp_count !== 6'd32) begin
      n_fail++;
      $display("FAIL sat_hold: tot=%0d cnt=%0d want 65535/32", total_ones, bus.resp_count);
    end
    clear_total     = 1'b1;
    bus.req_data[0] = 32'h0000_00FF;
    step();
    n_run++;
    if (total_ones !== 16'd8 || bus.resp_count !== 6'd8) begin
      n_fail++;
      $display("FAIL clear_xfer: tot=%0d cnt=%0d want 8/8", total_ones, bus.resp_count);
    end
    bus.req_valid = '0;
    step();
    n_run++;
    if (total_ones !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_alone: got %0d want 0", total_ones);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = {4{32'hFFFF_FFFF}};
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_run++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL mrst_ready_in: got %b want 0000", bus.req_ready);
    end
    step();
    n_run++;
    if (bus.resp_valid !== 1'b0 || total_ones !== '0 || bus.req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL mrst_state: valid=%b tot=%0d rdy=%b want 0/0/0000",
               bus.resp_valid, total_ones, bus.req_ready);
    end
    rst_n = 1'b1;
    #1;
    n_run++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mrst_first_grant: got %b want 0001", bus.req_ready);
    end
    step();
    n_run++;
    if (bus.resp_id !== 2'd0 || bus.resp_valid !== 1'b1 || total_ones !== 16'd32) begin
      n_fail++;
      $display("FAIL mrst_first_resp: id=%0d valid=%b tot=%0d want 0/1/32",
               bus.resp_id, bus.resp_valid, total_ones);
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_all_valid();
    test_back_pressure();
    test_pointer_skip();
    test_saturation();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/hw_rr_sched.md
Name: hw_rr_sched

Overview:
- Shares one Hamming-weight (popcount) datapath among NUM_REQ requesters, each with a valid/ready interface.
- Each cycle, a round-robin arbiter picks one pending requester and passes its word through the shared popcount sub-module.
- The count and requester ID are captured in a single output register with a valid/ready handshake.
- A saturating running total of all ones counted is kept for status and debug.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 32: word width presented to the popcount unit.
- CNT_W, 6: popcount width; must hold DATA_W, so 6 for 32 bits (value 32 needs bit 5).
- ID_W, 2: requester index width, clog2(NUM_REQ).
- TOT_W, 16: running-total width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_data  input  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant/accept; at most one bit high per cycle.
- resp_valid  output  1  result register holds a valid result.
- resp_ready  input  1  consumer accepts the result.
- resp_count  output  CNT_W  popcount of the granted word.
- resp_id  output  ID_W  index of the granted requester.
- clear_total  input  1  synchronous clear of total_ones.
- total_ones  output  TOT_W  saturating sum of all accepted counts.

Behaviour:
- Reset values: resp_valid=0, resp_count=0, resp_id=0, total_ones=0, rr_ptr=0.
- Reset is synchronous and active-low; asserting it mid-operation discards any held result, and no requester sees a completed transfer that cycle.
- can_accept = !resp_valid || resp_ready, i.e. the output register is empty or draining this cycle.
- Grant selection:
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit is the grant g.
  - req_ready[g] = can_accept; all other req_ready bits are 0.
  - req_ready is combinational from req_valid, rr_ptr and resp state. Requesters must not make valid depend on ready.
- Transfer: occurs on a cycle where req_valid[g] && req_ready[g]. At that edge:
  - resp_count <= popcount(req_data[g])
  - resp_id <= g
  - resp_valid <= 1
  - rr_ptr <= (g+1) mod NUM_REQ
- Latency: a word granted in cycle t appears on resp_* in cycle t+1.
- Throughput: one result per cycle while resp_ready=1.
- Drain: when resp_valid && resp_ready and there is no transfer, resp_valid <= 0.
- Simultaneous drain and transfer: the new result overwrites, resp_valid stays 1 and no bubble is inserted.
- Back-pressure: while resp_valid && !resp_ready:
  - resp_count and resp_id hold stable.
  - All req_ready are 0.
  - rr_ptr is unchanged.
- No valid requests: rr_ptr is unchanged and req_ready=0.
- Fairness: a continuously valid requester is granted within NUM_REQ transfers.
- Arithmetic: popcount of all-zeros is 0 and of all-ones is DATA_W (32). There is no truncation.
- total_ones:
  - On each transfer, total_ones <= min(total_ones + count, 2^TOT_W - 1).
  - If clear_total and a transfer occur in the same cycle, total_ones <= count of that transfer.
  - clear_total alone sets total_ones to 0.

Decomposition:
- Shared package hw_pkg holds DATA_W, CNT_W, TOT_W, NUM_REQ, ID_W, and the TOT_MAX constant (2^TOT_W - 1).
- Sub-module hw_popcount: purely combinational, DATA_W input, CNT_W output, instantiated once.
- Arbiter, output register and total counter stay in hw_rr_sched.

Test Plan:
- Reset and single request:
  - Stimulus: reset held 2 cycles, then req_valid=0001, req_data[0]=32'hFFFF_FFFF, resp_ready=1.
  - Required: req_ready=0001 in that cycle; next cycle resp_valid=1, resp_count=32, resp_id=0, total_ones=32.
- All requesters valid continuously:
  - Stimulus: data words 32'h1, 32'h3, 32'h7, 32'hF, resp_ready=1.
  - Required: grants in order 0,1,2,3,0,…; resp_count 1,2,3,4 on consecutive cycles with no bubbles.
- Back-pressure:
  - Stimulus: resp_ready=0 for 3 cycles with a result held.
  - Required: resp_count and resp_id stable, req_ready=0000, rr_ptr unchanged; when resp_ready=1, the same-cycle transfer occurs with no bubble.
- Pointer skip:
  - Stimulus: rr_ptr=1, req_valid=1001.
  - Required: grant requester 3, then requester 0 on the next accept.
- Saturation and clear:
  - Stimulus: preload by feeding 2048 words of 32'hFFFF_FFFF (total 65535 at the 2048th transfer), then one more word.
  - Required: total_ones stays 65535.
  - Stimulus: clear_total together with a transfer of 32'h0000_00FF.
  - Required: total_ones=8.
- Mid-operation reset:
  - Stimulus: assert rst_n=0 while resp_valid=1 and req_valid=1111.
  - Required: next cycle resp_valid=0, total_ones=0, req_ready=0000; after release, the first grant is requester 0.
